msi001_spi_rx: RTL
==================

MSI001_SPI_RX -- requirements
Module: msi001_spi_rx

Interface
REQ-001 SHALL have a single clock; reset is asynchronous and active-low.
REQ-002 clk  input  1  system clock; frequency SHALL be at least 4x the SPI clock rate.
REQ-003 reset  input  1  asynchronous, active-low; 0 = reset asserted.
REQ-004 spi_msi001_clk_in  input  1  SPI serial clock, idle low, asynchronous to clk.
REQ-005 spi_msi001_data_in  input  1  SPI serial data, MSB first, valid on spi clk rising edge.
REQ-006 spi_msi001_en_in  input  1  frame enable, active-low; rising edge latches the frame.
REQ-007 rx_ack  input  1  consumer acknowledge of rx_data.
REQ-008 rx_data  output  24  last good frame, bit 23 = first bit received.
REQ-009 rx_addr  output  4  register address = rx_data[3:0].
REQ-010 rx_valid  output  1  level; high while an unacknowledged good frame is held.
REQ-011 rx_overrun  output  1  sticky; a good frame arrived while rx_valid was high.
REQ-012 rx_frame_err  output  1  one-cycle pulse; frame closed with bit count != 24.
REQ-013 rx_frame_cnt  output  16  count of good frames; wraps 0xFFFF -> 0x0000.

Function
REQ-014 All three SPI inputs SHALL pass through 2-flop synchronizers, then a third delay flop for edge detection.
REQ-015 FSM states SHALL be IDLE, SHIFT, and CLOSE.
REQ-016 IDLE -> SHIFT on synchronized en falling edge; bit counter cleared to 0; shift register cleared to 0.
REQ-017 In SHIFT, each synchronized spi clk rising edge SHALL shift data into bit 0, shifting left, and increment the 5-bit bit counter.
REQ-018 Bit counter SHALL saturate at 25; additional clock edges SHALL neither wrap nor shift in further bits.
REQ-019 SHIFT -> CLOSE on synchronized en rising edge; an spi clk rising edge detected in that same cycle SHALL be ignored.
REQ-020 CLOSE SHALL last exactly one clk cycle, then go to IDLE.
REQ-021 In CLOSE with count == 24, the following SHALL update at the same edge:
  - rx_data <= shift register
  - rx_valid <= 1
  - rx_frame_cnt <= rx_frame_cnt + 1
REQ-022 In CLOSE with count != 24 (including 0 bits), rx_frame_err SHALL pulse for 1 cycle; rx_data, rx_valid and rx_frame_cnt SHALL be unchanged.
REQ-023 Latency: rx_valid SHALL rise at the 4th clk rising edge after en_in rises, with one clk of sampling uncertainty.
REQ-024 rx_ack sampled high while rx_valid = 1 SHALL clear rx_valid and rx_overrun at the next edge; rx_ack while rx_valid = 0 SHALL be ignored.
REQ-025 A good frame completing while rx_valid = 1 and rx_ack = 0 SHALL overwrite rx_data and set rx_overrun.
REQ-026 A good frame completing in the same cycle as an accepted rx_ack SHALL leave rx_valid = 1 and SHALL NOT set rx_overrun.
REQ-027 An en falling edge detected in CLOSE SHALL be honoured at IDLE entry; back-to-back frames with en high for >= 2 SPI clock periods SHALL all be received.
REQ-028 rx_addr SHALL be combinational from rx_data[3:0].

Reset
REQ-029 On reset = 0, regardless of clk, the following SHALL clear:
  - state = IDLE
  - rx_data = 0, rx_valid = 0, rx_overrun = 0, rx_frame_err = 0, rx_frame_cnt = 0
  - bit counter and shift register = 0
  - synchronizer flops reset to en = 1, clk = 0, data = 0
REQ-030 Reset asserted mid-frame SHALL discard the partial frame with no rx_valid and no rx_frame_err.
REQ-031 After reset release while en_in is already low, the receiver SHALL wait for an en rising edge followed by a falling edge before starting a frame.

Verification
REQ-032 Good frame: clk 10 MHz, SPI 2.5 MHz, send 0x123455 -> rx_data = 0x123455, rx_addr = 0x5, rx_valid = 1, rx_frame_cnt = 1.
REQ-033 Short/long frames: send 23 bits -> rx_frame_err pulse, rx_valid stays 0; send 30 bits -> rx_frame_err pulse, rx_frame_cnt unchanged.
REQ-034 Overrun: send 0xAAAAA0 then 0x55555F without ack -> rx_data = 0x55555F, rx_overrun = 1; assert rx_ack -> rx_valid = 0, rx_overrun = 0.
REQ-035 Simultaneous: rx_ack in the same cycle as the CLOSE of 0x000001 -> rx_valid = 1, rx_overrun = 0.
REQ-036 Reset abort: reset = 0 after 12 bits, release, send 0xFEDCBA -> only 0xFEDCBA reported, rx_frame_cnt = 1, no error pulse.
REQ-037 Wrap: preload 65535 good frames, send one more -> rx_frame_cnt = 0x0000.

Source files
------------

// File: rtl/msi001_spi_rx.sv
// msi001_spi_rx
//
// Receives 24-bit frames from an SPI master, MSB first. The data is sampled on
// the rising SPI clock and the frame is bracketed by an active-low enable. All
// SPI inputs are asynchronous to clk. They are brought into the clk domain
// before edge detection, so clk must run at least 4x the SPI clock rate.
//
// A frame of exactly 24 bits is published on rx_data/rx_valid and counted in
// rx_frame_cnt. Any other length produces a one-cycle rx_frame_err pulse and
// leaves the published frame untouched.
//
// Ports
//   clk                 system clock
//   reset               asynchronous reset, active-low
//   spi_msi001_clk_in   SPI serial clock (idle low), asynchronous
//   spi_msi001_data_in  SPI serial data, MSB first
//   spi_msi001_en_in    frame enable, active-low; its rising edge closes a frame
//   rx_ack              consumer acknowledge of the held frame
//   rx_data[23:0]       last good frame, bit 23 = first bit received
//   rx_addr[3:0]        register address field, rx_data[3:0]
//   rx_valid            high while an unacknowledged good frame is held
//   rx_overrun          sticky: a good frame replaced an unacknowledged one
//   rx_frame_err        one-cycle pulse when a frame closes with != 24 bits
//   rx_frame_cnt[15:0]  good-frame counter, wraps at 16 bits

module msi001_spi_rx (
  input  logic        clk,
  input  logic        reset,
  input  logic        spi_msi001_clk_in,
  input  logic        spi_msi001_data_in,
  input  logic        spi_msi001_en_in,
  input  logic        rx_ack,
  output logic [23:0] rx_data,
  output logic [3:0]  rx_addr,
  output logic        rx_valid,
  output logic        rx_overrun,
  output logic        rx_frame_err,
  output logic [15:0] rx_frame_cnt
);

  localparam int         DATA_W   = 24;
  localparam logic [4:0] BIT_GOOD = 5'd24;
  localparam logic [4:0] BIT_MAX  = 5'd25;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    CLOSE = 2'd2
  } state_t;

  // Bit counter increment that holds at BIT_MAX instead of wrapping.
  function automatic logic [4:0] sat_inc(input logic [4:0] cnt);
    return (cnt == BIT_MAX) ? cnt : cnt + 5'd1;
  endfunction

  state_t              state_q;
  state_t              state_d;

  logic                sclk_p0, sclk_p1, sclk_p2;
  logic                en_p0,   en_p1,   en_p2;
  logic                sdat_p0, sdat_p1;

  logic                sclk_rise;
  logic                en_rise;
  logic                en_fall;

  logic [1:0]          flush_cnt_q;
  logic                armed_q;
  logic                fall_pend_q;

  logic [4:0]          bit_cnt_q;
  logic [DATA_W-1:0]   shift_q;
  logic [DATA_W-1:0]   data_q;
  logic                valid_q;
  logic                overrun_q;
  logic                frame_err_q;
  logic [15:0]         frame_cnt_q;

  logic                start_frame;
  logic                shift_en;
  logic                frame_good;
  logic                frame_bad;
  logic                ack_take;

  // ---- Stage p0/p1: two-flop synchronizers; p2: delay flop for edge detection.
  // Reset values match the idle bus: enable high, clock low, data low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sclk_p0 <= 1'b0;
      sclk_p1 <= 1'b0;
      sclk_p2 <= 1'b0;
      en_p0   <= 1'b1;
      en_p1   <= 1'b1;
      en_p2   <= 1'b1;
      sdat_p0 <= 1'b0;
      sdat_p1 <= 1'b0;
    end else begin
      sclk_p0 <= spi_msi001_clk_in;
      sclk_p1 <= sclk_p0;
      sclk_p2 <= sclk_p1;
      en_p0   <= spi_msi001_en_in;
      en_p1   <= en_p0;
      en_p2   <= en_p1;
      sdat_p0 <= spi_msi001_data_in;
      sdat_p1 <= sdat_p0;
    end
  end

  // Data shares the clock's synchronizer depth, so sdat_p1 is aligned with
  // the cycle in which the SPI clock rising edge is seen.
  assign sclk_rise = sclk_p1 & ~sclk_p2;
  assign en_rise   = en_p1 & ~en_p2;
  assign en_fall   = ~en_p1 & en_p2;

  // ---- Start qualification.
  // The enable synchronizer resets to "high". If the real enable is already
  // low when reset is released, that would look like a falling edge. The
  // receiver only arms once the synchronizer has flushed and has seen the
  // enable high. fall_pend_q carries a falling edge seen during CLOSE into
  // the following IDLE cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flush_cnt_q <= 2'd0;
      armed_q     <= 1'b0;
      fall_pend_q <= 1'b0;
    end else begin
      if (flush_cnt_q != 2'd2) begin
        flush_cnt_q <= flush_cnt_q + 2'd1;
      end
      if ((flush_cnt_q == 2'd2) && en_p1) begin
        armed_q <= 1'b1;
      end
      fall_pend_q <= (state_q == CLOSE) && en_fall;
    end
  end

  assign start_frame = (state_q == IDLE) && ((en_fall && armed_q) || fall_pend_q);
  // A clock edge coinciding with the closing enable edge is dropped.
  assign shift_en    = (state_q == SHIFT) && !en_rise && sclk_rise &&
                       (bit_cnt_q != BIT_MAX);
  assign frame_good  = (state_q == CLOSE) && (bit_cnt_q == BIT_GOOD);
  assign frame_bad   = (state_q == CLOSE) && (bit_cnt_q != BIT_GOOD);
  assign ack_take    = rx_ack && valid_q;

  // ---- Frame FSM.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_frame) state_d = SHIFT;
      SHIFT:   if (en_rise)     state_d = CLOSE;
      CLOSE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---- Shift register and bit counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bit_cnt_q <= 5'd0;
      shift_q   <= '0;
    end else if (start_frame) begin
      bit_cnt_q <= 5'd0;
      shift_q   <= '0;
    end else if (shift_en) begin
      bit_cnt_q <= sat_inc(bit_cnt_q);
      shift_q   <= {shift_q[DATA_W-2:0], sdat_p1};
    end
  end

  // ---- Published frame and status.
  // A good frame wins over an acknowledge in the same cycle: valid stays set.
  // Overrun is only raised when the replaced frame was not being acknowledged.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q      <= '0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
      frame_cnt_q <= 16'd0;
    end else begin
      frame_err_q <= frame_bad;
      if (frame_good) begin
        data_q      <= shift_q;
        valid_q     <= 1'b1;
        frame_cnt_q <= frame_cnt_q + 16'd1;
        overrun_q   <= valid_q && !ack_take;
      end else if (ack_take) begin
        valid_q     <= 1'b0;
        overrun_q   <= 1'b0;
      end
    end
  end

  assign rx_data      = data_q;
  assign rx_addr      = data_q[3:0];
  assign rx_valid     = valid_q;
  assign rx_overrun   = overrun_q;
  assign rx_frame_err = frame_err_q;
  assign rx_frame_cnt = frame_cnt_q;

endmodule
